// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: ADD/SUB/AND in one execute cycle, MUL as a WIDTH-cycle shift-add.
// Optional build macro ALU_PERF_CNT_EN adds the saturating op_count response counter port.
module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           TT,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 cout
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               cout_q,   cout_d;
  logic [2*WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic [1:0]         tt_q,     tt_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  // req_ready is gated by rst_n so it reads 0 for as long as reset is held.
  assign req_ready = (state_q == S_IDLE) & rst_n;
  assign rsp_valid = (state_q == S_DONE);
  assign Result    = result_q;
  assign cout      = cout_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    tt_d     = tt_q;
    sum      = '0;
    diff     = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          opa_d = {{WIDTH{1'b0}}, A};
          opb_d = B;
          tt_d  = TT;
          cnt_d = '0;
          if (TT == OP_MUL) begin
            result_d = '0;
            cout_d   = 1'b0;
            state_d  = S_MUL;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        sum  = {1'b0, opa_q[WIDTH-1:0]} + {1'b0, opb_q};
        diff = {1'b0, opa_q[WIDTH-1:0]} - {1'b0, opb_q};
        case (tt_q)
          OP_ADD: begin
            result_d = {{(WIDTH-1){1'b0}}, sum};
            cout_d   = sum[WIDTH];
          end
          OP_SUB: begin
            // The extra top bit of the widened difference is the borrow (A < B).
            result_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            cout_d   = diff[WIDTH];
          end
          default: begin
            result_d = {{WIDTH{1'b0}}, opa_q[WIDTH-1:0] & opb_q};
            cout_d   = 1'b0;
          end
        endcase
        state_d = S_DONE;
      end
      S_MUL: begin
        // Multiplicand shifts left and multiplier right, so bit i lines up with cycle i.
        if (opb_q[0]) begin
          result_d = result_q + opa_q;
        end
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Operand working registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    tt_q  <= tt_d;
  end

`ifdef ALU_PERF_CNT_EN
  logic [15:0] op_count_q, op_count_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == S_DONE) && rsp_ready) begin
      op_count_d = sat_inc16(op_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vector table, hand-written hold/reset sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_alu_seq_unit;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] TT;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] Result;
  logic       cout;
`ifdef ALU_PERF_CNT_EN
  logic [15:0] op_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int ops_since_reset = 0;

  alu_seq_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A         (A),
    .B         (B),
    .TT        (TT),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .Result    (Result),
    .cout      (cout)
`ifdef ALU_PERF_CNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] tt;
    logic [7:0] res;
    logic       co;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions. Latency is counted in cycles
  // from the handshake cycle to the first cycle showing rsp_valid.
  task automatic model(input int a, input int b, input int tt,
                       output int res, output int co, output int lat);
    case (tt)
      0: begin res = a + b;               co = (a + b > 15) ? 1 : 0; end
      1: begin res = (a - b + 16) % 16;   co = (a < b) ? 1 : 0;      end
      2: begin res = a * b;               co = 0;                    end
      default: begin res = a & b;         co = 0;                    end
    endcase
    lat = (tt == 2) ? 5 : 2;
  endtask

  // Called and returns on a falling edge; operands change after accept to prove they were latched.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] tt,
                        input int hold, input bit poke,
                        output logic [7:0] res, output logic co, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    A = a; B = b; TT = tt; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    A = 4'($urandom); B = 4'($urandom); TT = 2'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    res = Result;
    co  = cout;
    for (int i = 0; i < hold; i++) begin
      if (poke) req_valid = (i == 1);
      @(negedge clk);
      req_valid = 1'b0;
      check("hold_result", 32'(Result), 32'(res));
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      if (poke) check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ops_since_reset++;
  endtask

  initial begin
    logic [7:0] res;
    logic       co;
    int         lat;
    int         e_res, e_co, e_lat;
    logic [3:0] ra, rb;
    logic [1:0] rt;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  tt: 2'b00, res: 8'd8,   co: 1'b0, lat: 2};
    vecs[1] = '{a: 4'd15, b: 4'd15, tt: 2'b00, res: 8'd30,  co: 1'b1, lat: 2};
    vecs[2] = '{a: 4'd5,  b: 4'd5,  tt: 2'b01, res: 8'd0,   co: 1'b0, lat: 2};
    vecs[3] = '{a: 4'd3,  b: 4'd10, tt: 2'b01, res: 8'd9,   co: 1'b1, lat: 2};
    vecs[4] = '{a: 4'd15, b: 4'd15, tt: 2'b10, res: 8'd225, co: 1'b0, lat: 5};
    vecs[5] = '{a: 4'd7,  b: 4'd9,  tt: 2'b10, res: 8'd63,  co: 1'b0, lat: 5};
    vecs[6] = '{a: 4'd12, b: 4'd10, tt: 2'b11, res: 8'd8,   co: 1'b0, lat: 2};
    vecs[7] = '{a: 4'd0,  b: 4'd15, tt: 2'b01, res: 8'd1,   co: 1'b1, lat: 2};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; A = '0; B = '0; TT = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_PERF_CNT_EN
    check("rst_op_count", 32'(op_count), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].tt, 0, 1'b0, res, co, lat);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // AND held in DONE for 3 cycles with a stray request pulse that must not be taken.
    run_op(4'b1100, 4'b0011, 2'b11, 3, 1'b1, res, co, lat);
    check("and_hold_result", 32'(res), 32'd0);
    check("after_rsp_req_ready", 32'(req_ready), 32'd1);
    check("after_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("no_spurious_rsp", 32'(rsp_valid), 32'd0);

    // Reset asserted in the middle of a multiply.
    A = 4'd15; B = 4'd15; TT = 2'b10; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_mul_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_mul_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_mul_rst_result", 32'(Result), 32'd0);
    check("mid_mul_rst_req_ready", 32'(req_ready), 32'd0);
    ops_since_reset = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    run_op(4'd1, 4'd1, 2'b00, 0, 1'b0, res, co, lat);
    check("post_rst_add_result", 32'(res), 32'd2);
    check("post_rst_add_cout", 32'(co), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rt = 2'($urandom);
      model(int'(ra), int'(rb), int'(rt), e_res, e_co, e_lat);
      run_op(ra, rb, rt, $urandom_range(0, 2), 1'b0, res, co, lat);
      check($sformatf("rnd%0d_result", i), 32'(res), 32'(e_res));
      check($sformatf("rnd%0d_cout", i), 32'(co), 32'(e_co));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
`ifdef ALU_PERF_CNT_EN
      if (ops_since_reset == 12) check("op_count_12", 32'(op_count), 32'd12);
`endif
    end

`ifdef ALU_PERF_CNT_EN
    check("op_count_total", 32'(op_count), 32'(ops_since_reset));
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    run_op(4'd2, 4'd3, 2'b00, 0, 1'b0, res, co, lat);
    check("op_count_saturate", 32'(op_count), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
